// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch stage: owns the PC, issues sequential requests to a
// one-cycle-latency instruction memory and buffers {pc, instr} pairs for decode.
module fetch_queue #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter int              DEPTH    = 4,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  output logic                       imem_req,
  output logic [PC_W-1:0]            imem_addr,
  input  logic [INS_W-1:0]           imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_W-1:0]            out_pc,
  output logic [INS_W-1:0]           out_instr,
  input  logic                       redirect,
  input  logic [PC_W-1:0]            redirect_pc,
  input  logic                       halt,
  output logic [PC_W-1:0]            fetch_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [PC_W-1:0]  pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [PC_W-1:0]  req_pc_q, req_pc_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  logic [PC_W-1:0]  pc_mem_q  [DEPTH];
  logic [INS_W-1:0] ins_mem_q [DEPTH];

  logic             pop;
  logic             push;
  logic             issue;
  logic [CW:0]      credit;

  assign pop  = (count_q != '0) & out_ready;
  assign push = inflight_q & ~redirect;

  // Slots already promised: stored entries plus the response still on its way,
  // minus the one decode is taking this cycle.
  assign credit = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);
  assign issue  = ~halt & ~redirect & (credit < (CW+1)'(DEPTH));

  always_comb begin
    pc_d       = pc_q;
    inflight_d = issue;
    req_pc_d   = req_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect) begin
      pc_d       = redirect_pc & ~PC_W'(3);
      inflight_d = 1'b0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        pc_d     = pc_q + PC_W'(4);
        req_pc_d = pc_q;
      end
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      inflight_q <= 1'b0;
      req_pc_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      req_pc_q   <= req_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is cleared on reset so the head reads as zero while empty.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        pc_mem_q[gi]  <= '0;
        ins_mem_q[gi] <= '0;
      end else if (push && (wr_ptr_q == AW'(gi))) begin
        pc_mem_q[gi]  <= req_pc_q;
        ins_mem_q[gi] <= imem_rdata;
      end
    end
  end

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign fetch_pc  = pc_q;
  assign out_valid = (count_q != '0);
  assign out_pc    = pc_mem_q[rd_ptr_q];
  assign out_instr = ins_mem_q[rd_ptr_q];
  assign count     = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: requests are recorded as they issue and matched
// against entries popped by decode; a per-cycle model checks occupancy and credit.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [8:0]  out_pc;
  logic [31:0] out_instr;
  logic        redirect;
  logic [8:0]  redirect_pc;
  logic        halt;
  logic [8:0]  fetch_pc;
  logic [2:0]  count;

  int n_run  = 0;
  int n_fail = 0;

  logic [40:0] sb[$];
  logic [8:0]  exp_pc = '0;
  bit          prev_req = 1'b0;
  int          req_total = 0;
  int          lat_k;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk        (clk),
    .reset      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_instr  (out_instr),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .halt       (halt),
    .fetch_pc   (fetch_pc),
    .count      (count)
  );

  function automatic logic [31:0] ifn(input logic [8:0] a);
    return {a, 23'h2A5A5 ^ {14'd0, a}};
  endfunction

  // Synchronous instruction memory with one-cycle read latency.
  always @(posedge clk) begin
    if (imem_req) imem_rdata <= ifn(imem_addr);
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Sample 1 time unit before each rising edge; inputs change on the falling edge.
  always @(negedge clk) begin
    int  exp_cnt;
    bit  exp_valid;
    bit  exp_pop;
    bit  exp_req;
    logic [40:0] e;
    #4;
    if (!rst_n) begin
      sb.delete();
      exp_pc   = '0;
      prev_req = 1'b0;
    end else begin
      exp_cnt   = sb.size() - int'(prev_req);
      exp_valid = (exp_cnt != 0);
      exp_pop   = exp_valid && out_ready && !redirect;
      exp_req   = !halt && !redirect &&
                  ((exp_cnt + int'(prev_req) - int'(exp_valid && out_ready)) < 4);
      chk("count", 64'(count), 64'(exp_cnt));
      chk("out_valid", 64'(out_valid), 64'(exp_valid));
      chk("fetch_pc", 64'(fetch_pc), 64'(exp_pc));
      chk("imem_req", 64'(imem_req), 64'(exp_req));
      chk("imem_addr", 64'(imem_addr), 64'(exp_pc));
      if (redirect) begin
        sb.delete();
        exp_pc   = redirect_pc & 9'h1FC;
        prev_req = 1'b0;
      end else begin
        if (exp_pop) begin
          if (sb.size() == 0) begin
            chk("sb_nonempty", 64'(0), 64'(1));
          end else begin
            e = sb.pop_front();
            $display("[TB] pop pc=%03h instr=%08h", out_pc, out_instr);
            chk("out_pc", 64'(out_pc), 64'(e[40:32]));
            chk("out_instr", 64'(out_instr), 64'(e[31:0]));
          end
        end
        if (imem_req) begin
          sb.push_back({imem_addr, ifn(imem_addr)});
          exp_pc = exp_pc + 9'd4;
          req_total++;
        end
        prev_req = imem_req;
      end
    end
  end

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset(input logic ready);
    @(negedge clk);
    rst_n     = 1'b0;
    out_ready = ready;
    halt      = 1'b0;
    redirect  = 1'b0;
    cycles(2);
    rst_n     = 1'b1;
    req_total = 0;
  endtask

  task automatic wait_count(input string tag, input logic [2:0] target);
    for (int i = 0; i < 20 && count != target; i++) @(negedge clk);
    chk(tag, 64'(count), 64'(target));
  endtask

  initial begin
    rst_n       = 1'b0;
    out_ready   = 1'b1;
    halt        = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    cycles(2);
    #1;
    chk("rst_imem_req", 64'(imem_req), 64'(1));
    chk("rst_imem_addr", 64'(imem_addr), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_out_instr", 64'(out_instr), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    halt = 1'b1;
    #1;
    chk("rst_halt_req", 64'(imem_req), 64'(0));
    halt = 1'b0;

    // Streaming from reset: first entry two cycles after the first request.
    @(negedge clk);
    rst_n = 1'b1;
    for (lat_k = 1; lat_k <= 10; lat_k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("lat_reset", 64'(lat_k), 64'(2));
    cycles(12);

    // Decode stalled from reset: exactly DEPTH requests, then drain in order.
    do_reset(1'b0);
    cycles(10);
    chk("stall_reqs", 64'(req_total), 64'(4));
    chk("stall_count", 64'(count), 64'(4));
    chk("stall_req_low", 64'(imem_req), 64'(0));
    out_ready = 1'b1;
    cycles(12);

    // Redirect with three entries queued and one in flight.
    do_reset(1'b0);
    wait_count("reach_cnt3", 3'd3);
    redirect    = 1'b1;
    redirect_pc = 9'h123;
    out_ready   = 1'b1;
    for (lat_k = 1; lat_k <= 10; lat_k++) begin
      @(negedge clk);
      redirect = 1'b0;
      if (lat_k == 1) chk("redir_count0", 64'(count), 64'(0));
      if (out_valid) break;
    end
    chk("lat_redirect", 64'(lat_k), 64'(3));
    chk("redir_first_pc", 64'(out_pc), 64'(9'h120));
    cycles(8);

    // PC wrap-around after redirect near the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 9'h1FC;
    @(negedge clk);
    redirect = 1'b0;
    cycles(10);

    // Halt mid-stream with decode stalled; fetch resumes sequentially.
    out_ready = 1'b0;
    halt      = 1'b1;
    cycles(5);
    halt = 1'b0;
    cycles(6);
    out_ready = 1'b1;
    cycles(8);

    // Redirect while halted: fetch resumes at the new target once halt drops.
    halt = 1'b1;
    cycles(2);
    redirect    = 1'b1;
    redirect_pc = 9'h081;
    @(negedge clk);
    redirect = 1'b0;
    cycles(2);
    chk("halt_redir_pc", 64'(fetch_pc), 64'(9'h080));
    halt = 1'b0;
    cycles(8);

    // Asynchronous reset between edges with two entries queued and one in flight.
    do_reset(1'b0);
    wait_count("reach_cnt2", 3'd2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'(0));
    chk("async_count", 64'(count), 64'(0));
    chk("async_pc", 64'(fetch_pc), 64'(0));
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    cycles(10);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
